// File: rtl/ram_scan_ctrl.sv
// Controller for the 32x4 single-port RAM: FILL writes a pattern to every word.
// SCAN reads each word back and holds it, with its address, on the outputs for DWELL cycles.
module ram_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  input  logic [3:0] fill_data,
  input  logic       incr,
  output logic [4:0] ram_address,
  output logic [3:0] ram_data,
  output logic       ram_wren,
  input  logic [3:0] ram_q,
  output logic [4:0] out_addr,
  output logic [3:0] out_data,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t           state_reg;
  logic [4:0]       addr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [4:0]       out_addr_reg;
  logic [3:0]       out_data_reg;
  logic             out_valid_reg;
  logic [3:0]       fill_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      cnt_reg       <= '0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            addr_reg  <= '0;
            state_reg <= mode ? S_FILL : S_ISSUE;
          end
        end
        S_FILL: begin
          if (abort) begin
            state_reg <= S_IDLE;
          end else if (addr_reg == 5'd31) begin
            state_reg <= S_DONE;
          end else begin
            addr_reg <= addr_reg + 5'd1;
          end
        end
        S_ISSUE: begin
          state_reg <= abort ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          // ram_q is valid now: one cycle after the address was presented in ISSUE
          if (abort) begin
            state_reg <= S_IDLE;
          end else begin
            out_data_reg  <= ram_q;
            out_addr_reg  <= addr_reg;
            cnt_reg       <= DWELL_LAST;
            out_valid_reg <= 1'b1;
            state_reg     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (abort) begin
            state_reg <= S_IDLE;
          end else if (cnt_reg == '0) begin
            if (addr_reg == 5'd31) begin
              state_reg <= S_DONE;
            end else begin
              addr_reg  <= addr_reg + 5'd1;
              state_reg <= S_ISSUE;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // RAM-side signals decode straight from the state register so reset clears them at once
  assign fill_word   = fill_data + (incr ? addr_reg[3:0] : 4'd0);
  assign ram_wren    = (state_reg == S_FILL);
  assign ram_data    = (state_reg == S_FILL) ? fill_word : 4'd0;
  assign ram_address = (state_reg == S_FILL || state_reg == S_ISSUE ||
                        state_reg == S_WAIT || state_reg == S_HOLD) ? addr_reg : 5'd0;
  assign busy        = (state_reg == S_FILL || state_reg == S_ISSUE ||
                        state_reg == S_WAIT || state_reg == S_HOLD);
  assign done        = (state_reg == S_DONE);
  assign out_addr    = out_addr_reg;
  assign out_data    = out_data_reg;
  assign out_valid   = out_valid_reg;

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Bench for ram_scan_ctrl: two instances (DWELL=4 and DWELL=1), each on its own RAM model,
// checked cycle by cycle against a word-timeline model of fills and scans.
module tb_ram_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset, start, mode, abort, incr;
  logic [3:0] fill_data;
  logic       sel;

  logic [4:0] ra0, ra1, oa0, oa1;
  logic [3:0] rd0, rd1, rq0, rq1, od0, od1;
  logic       rw0, rw1, ov0, ov1, b0, b1, d0, d1;
  logic       start0, start1;

  logic [4:0] p_ra, p_oa;
  logic [3:0] p_rd, p_od;
  logic       p_rw, p_ov, p_busy, p_done;

  logic [3:0] ram0 [32];
  logic [3:0] ram1 [32];
  logic [3:0] exp_mem [2][32];
  logic [4:0] exp_oaddr [2];
  logic [3:0] exp_odata [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign start0 = start && !sel;
  assign start1 = start && sel;

  ram_scan_ctrl #(.DWELL(4), .CNT_W(26)) dut (
    .clock(clock), .reset(reset), .start(start0), .mode(mode), .abort(abort),
    .fill_data(fill_data), .incr(incr), .ram_address(ra0), .ram_data(rd0),
    .ram_wren(rw0), .ram_q(rq0), .out_addr(oa0), .out_data(od0),
    .out_valid(ov0), .busy(b0), .done(d0)
  );

  ram_scan_ctrl #(.DWELL(1), .CNT_W(26)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .mode(mode), .abort(abort),
    .fill_data(fill_data), .incr(incr), .ram_address(ra1), .ram_data(rd1),
    .ram_wren(rw1), .ram_q(rq1), .out_addr(oa1), .out_data(od1),
    .out_valid(ov1), .busy(b1), .done(d1)
  );

  // Synchronous RAMs with one-cycle registered read, not affected by reset
  always @(posedge clock) begin
    if (rw0) ram0[ra0] <= rd0;
    rq0 <= ram0[ra0];
    if (rw1) ram1[ra1] <= rd1;
    rq1 <= ram1[ra1];
  end

  assign p_ra   = sel ? ra1 : ra0;
  assign p_rd   = sel ? rd1 : rd0;
  assign p_rw   = sel ? rw1 : rw0;
  assign p_oa   = sel ? oa1 : oa0;
  assign p_od   = sel ? od1 : od0;
  assign p_ov   = sel ? ov1 : ov0;
  assign p_busy = sel ? b1 : b0;
  assign p_done = sel ? d1 : d0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, p_busy, 0);
    check({tag, "_done"}, p_done, 0);
    check({tag, "_wren"}, p_rw, 0);
    check({tag, "_valid"}, p_ov, 0);
    check({tag, "_oaddr"}, p_oa, exp_oaddr[sel]);
    check({tag, "_odata"}, p_od, exp_odata[sel]);
  endtask

  // cut_kind: 0 = none, 1 = abort at word cut_at, 2 = async reset at word cut_at
  task automatic fill(input logic [3:0] base, input logic inc, input bit live_rand,
                      input int cut_at, input int cut_kind);
    logic [3:0] w;
    @(negedge clock);
    mode = 1'b1; start = 1'b1; fill_data = base; incr = inc;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (live_rand) begin
        fill_data = 4'($urandom);
        incr = 1'($urandom);
      end
      #1;
      w = 4'(fill_data + (incr ? i : 0));
      check("fill_wren", p_rw, 1);
      check("fill_addr", p_ra, i);
      check("fill_data", p_rd, w);
      check("fill_busy", p_busy, 1);
      check("fill_done", p_done, 0);
      if (i == cut_at && cut_kind == 1) begin
        exp_mem[sel][i] = w;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        #1;
        check_idle("fill_abort");
        return;
      end
      if (i == cut_at && cut_kind == 2) begin
        reset = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
          exp_oaddr[s] = '0;
          exp_odata[s] = '0;
        end
        check_idle("fill_reset");
        check("fill_reset_addr", p_ra, 0);
        check("fill_reset_data", p_rd, 0);
        @(negedge clock);
        reset = 1'b0;
        return;
      end
      exp_mem[sel][i] = w;
      @(negedge clock);
    end
    #1;
    check("fill_end_done", p_done, 1);
    check("fill_end_busy", p_busy, 0);
    check("fill_end_wren", p_rw, 0);
    @(negedge clock);
    #1;
    check("fill_after_done", p_done, 0);
  endtask

  // Word k is issued at cycle 1+k*(d+2) after start is sampled and first shown at 3+k*(d+2)
  task automatic scan(input int d, input bit hold, input int abort_c);
    int n;
    int k;
    bit v;
    n = 32 * (d + 2) + 1;
    @(negedge clock);
    mode = 1'b0; start = 1'b1;
    @(negedge clock);
    if (!hold) start = 1'b0;
    for (int c = 1; c <= n; c++) begin
      #1;
      v = (c >= 3) && (c < n) && ((c - 3) % (d + 2) == 0);
      if (v) begin
        k = (c - 3) / (d + 2);
        exp_oaddr[sel] = 5'(k);
        exp_odata[sel] = exp_mem[sel][k];
      end
      check("scan_valid", p_ov, v);
      check("scan_busy", p_busy, c < n);
      check("scan_done", p_done, c == n);
      check("scan_wren", p_rw, 0);
      check("scan_oaddr", p_oa, exp_oaddr[sel]);
      check("scan_odata", p_od, exp_odata[sel]);
      if (c < n && ((c - 1) % (d + 2)) < 2)
        check("scan_raddr", p_ra, (c - 1) / (d + 2));
      if (c == abort_c) begin
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        #1;
        check_idle("scan_abort");
        for (int j = 0; j < 4; j++) begin
          @(negedge clock);
          #1;
          check_idle("post_abort");
        end
        return;
      end
      @(negedge clock);
    end
    #1;
    check("scan_end_busy", p_busy, 0);
    check("scan_end_done", p_done, 0);
    check("scan_end_odata", p_od, exp_odata[sel]);
    if (hold) begin
      @(negedge clock);
      #1;
      check("rescan_busy", p_busy, 1);
      check("rescan_raddr", p_ra, 0);
      start = 1'b0;
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      #1;
      check_idle("rescan_abort");
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram0[i] = '0;
      ram1[i] = '0;
      exp_mem[0][i] = '0;
      exp_mem[1][i] = '0;
    end
    for (int s = 0; s < 2; s++) begin
      exp_oaddr[s] = '0;
      exp_odata[s] = '0;
    end
    sel = 1'b0;
    reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; incr = 1'b0; fill_data = '0;
    repeat (2) @(negedge clock);
    #1;
    check_idle("reset0");
    check("reset0_raddr", p_ra, 0);
    check("reset0_rdata", p_rd, 0);
    sel = 1'b1;
    #1;
    check_idle("reset1");
    sel = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Incrementing fill from 3, then full scan
    fill(4'h3, 1'b1, 1'b0, -1, 0);
    scan(4, 1'b0, 0);
    // Constant fill of A
    fill(4'hA, 1'b0, 1'b0, -1, 0);
    scan(4, 1'b0, 0);
    // Abort in the second HOLD cycle of word 5, then a fresh scan
    scan(4, 1'b0, 3 + 5 * 6 + 1);
    scan(4, 1'b0, 0);
    // Async reset during fill at word 10
    fill(4'($urandom), 1'b1, 1'b0, 10, 2);
    scan(4, 1'b0, 0);
    // Live-varying fill inputs, then abort in a fill at a random word
    fill(4'($urandom), 1'b1, 1'b1, -1, 0);
    scan(4, 1'b0, 0);
    fill(4'($urandom), 1'($urandom), 1'b1, int'($urandom_range(0, 31)), 1);
    scan(4, 1'b0, int'($urandom_range(3, 190)));
    scan(4, 1'b0, 0);
    // start held high: one scan, a second only after done
    scan(4, 1'b1, 0);
    // DWELL=1 instance
    sel = 1'b1;
    fill(4'($urandom), 1'b1, 1'b1, -1, 0);
    scan(1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
